// File: rtl/shift_array_controller.sv
// Controller for an external DEPTH-stage shift register array: tracks which stages hold real words.
// Latency: a word reaches out_data after exactly DEPTH shifts, including the shift that accepts it.
// Backpressure: a stalled output (out_valid=1, out_ready=0) freezes all shifting and drops in_ready.
//
// Ports:
//   clk, reset            single clock, asynchronous active-low reset
//   in_data/valid/ready   upstream valid-ready interface
//   flush                 single-cycle request to drain every held word
//   sr_in/enable/out      connection to the shift register array (in, enable, oldest stage)
//   out_data/valid/ready  downstream valid-ready interface
//   occupancy             count of real words currently held in the array
//   flush_done            high for the cycle in which a drain finishes and the FSM returns to RUN

module shift_array_controller #(
  parameter  int BIT_WIDTH = 8,
  parameter  int DEPTH     = 8,
  localparam int OCC_W     = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BIT_WIDTH-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 flush,
  output logic [BIT_WIDTH-1:0] sr_in,
  output logic                 sr_enable,
  input  logic [BIT_WIDTH-1:0] sr_out,
  output logic [BIT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OCC_W-1:0]     occupancy,
  output logic                 flush_done
);

  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t             state;
  state_t             state_nxt;

  // One valid tag per array stage; tags[DEPTH-1] describes sr_out.
  logic [DEPTH-1:0]   tags;
  logic [OCC_W-1:0]   occ;

  logic               in_fire;
  logic               out_fire;
  logic               occ_empty;
  logic               bubble;
  logic               shift;

  // ------------------------------------------------------------------
  // Datapath-side combinational signals
  // ------------------------------------------------------------------
  assign occ_empty = (occ == '0);
  assign out_valid = tags[DEPTH-1];
  assign out_data  = out_valid ? sr_out : '0;
  assign occupancy = occ;

  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // While draining, an empty output stage lets us push a bubble in to
  // advance the held words without waiting for new input.
  assign bubble    = (state == ST_FLUSH) & ~occ_empty & ~out_valid;

  assign shift     = in_fire | out_fire | bubble;
  assign sr_enable = shift;
  assign sr_in     = in_fire ? in_data : '0;

  // ------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // ------------------------------------------------------------------
  // FSM: next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN: begin
        if (flush) begin
          state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        // A further flush request here is deliberately ignored.
        if (occ_empty) begin
          state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // ------------------------------------------------------------------
  // FSM: output logic
  // ------------------------------------------------------------------
  always_comb begin
    in_ready   = 1'b0;
    flush_done = 1'b0;
    case (state)
      ST_RUN: begin
        // Accepting a word shifts the whole array, so the oldest stage
        // must be either empty or leaving this cycle.
        in_ready = ~out_valid | out_ready;
      end
      ST_FLUSH: begin
        flush_done = occ_empty;
      end
      default: begin
        in_ready   = 1'b0;
        flush_done = 1'b0;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Valid-tag shift register, moves in lock-step with the array
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tags <= '0;
    end else if (shift) begin
      tags <= {tags[DEPTH-2:0], in_fire};
    end
  end

  // ------------------------------------------------------------------
  // Occupancy counter
  // ------------------------------------------------------------------
  // Accepting into a full array always coincides with an output pop, so
  // the guards below never actually clip; they only keep the range hard.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ <= '0;
    end else if (in_fire && !out_fire && (occ != OCC_FULL)) begin
      occ <= occ + OCC_ONE;
    end else if (out_fire && !in_fire && !occ_empty) begin
      occ <= occ - OCC_ONE;
    end
  end

  // ------------------------------------------------------------------
  // Consistency properties
  // ------------------------------------------------------------------
  a_occ_matches_tags : assert property (
    @(posedge clk) disable iff (!reset) int'(occ) == $countones(tags)
  );

  a_occ_in_range : assert property (
    @(posedge clk) disable iff (!reset) occ <= OCC_FULL
  );

  a_no_accept_in_flush : assert property (
    @(posedge clk) disable iff (!reset) (state == ST_FLUSH) |-> !in_ready
  );

endmodule

// File: doc/shift_array_controller.md
SHIFT_ARRAY_CONTROLLER -- requirements
Module: shift_array_controller

Interface
REQ-001 Parameter BIT_WIDTH, default 8: data word width in bits.
REQ-002 Parameter DEPTH, default 8: number of stages in the downstream shift register array; minimum 2.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; the clock and reset ports are named as the codebase does, but this reset is active-low and asynchronous.
REQ-005 in_data  input  BIT_WIDTH  upstream data word.
REQ-006 in_valid  input  1  upstream word present.
REQ-007 in_ready  output  1  controller accepts in_data this cycle.
REQ-008 flush  input  1  single-cycle request to drain all held words.
REQ-009 sr_in  output  BIT_WIDTH  data driven into the shift register array "in" port.
REQ-010 sr_enable  output  1  shift strobe driven to the shift register array "enable" port.
REQ-011 sr_out  input  BIT_WIDTH  shift register array "out" port (oldest stage).
REQ-012 out_data  output  BIT_WIDTH  downstream data word.
REQ-013 out_valid  output  1  out_data holds a real accepted word.
REQ-014 out_ready  input  1  downstream accepts out_data.
REQ-015 occupancy  output  $clog2(DEPTH+1)  count of real words currently held in the array.
REQ-016 flush_done  output  1  one-cycle pulse when a flush completes.

Function
REQ-017 The controller SHALL keep a DEPTH-bit valid-tag shift register that mirrors the array, one tag per stage; tag[DEPTH-1] corresponds to sr_out.
REQ-018 out_valid SHALL equal tag[DEPTH-1]; out_data SHALL equal sr_out when out_valid=1, else 0.
REQ-019 FSM states: RUN and FLUSH.
REQ-020 in_ready SHALL be 1 only in RUN and when (out_valid=0 or out_ready=1).
REQ-021 in_fire = in_valid and in_ready; out_fire = out_valid and out_ready.
REQ-022 Shift condition:
- shift = in_fire, or out_fire, or (state=FLUSH and occupancy!=0 and out_valid=0).
REQ-023 sr_enable SHALL equal shift (combinational, same cycle).
REQ-024 sr_in SHALL be in_data when in_fire=1, else 0 (bubble).
REQ-025 On each shift, tags SHALL shift by one toward tag[DEPTH-1], and tag[0] SHALL load in_fire.
REQ-026 occupancy update: +1 on in_fire without out_fire; -1 on out_fire without in_fire; unchanged when both or neither occur; it SHALL never exceed DEPTH or go below 0.
REQ-027 Latency: a word accepted at a clock edge SHALL reach out_data only after exactly DEPTH shifts, counting the accepting shift; order SHALL be preserved with no loss or duplication.
REQ-028 Without input, held words SHALL not advance except on out_fire or in FLUSH; a stalled output (out_valid=1, out_ready=0) SHALL freeze all shifting.
REQ-029 RUN->FLUSH on flush=1; flush SHALL be ignored while already in FLUSH.
REQ-030 In FLUSH, bubbles SHALL be inserted until occupancy=0, then the FSM SHALL return to RUN with flush_done=1 for exactly that transition cycle.
REQ-031 flush asserted with occupancy=0 SHALL enter FLUSH and return to RUN on the next edge with a flush_done pulse.
REQ-032 in_fire and flush in the same cycle: the word SHALL be accepted and included in the drain.

Reset
REQ-033 On reset=0, asynchronously: tags=0, occupancy=0, state=RUN, flush_done=0; hence out_valid=0, out_data=0, sr_enable=0.
REQ-034 Reset asserted mid-stream or mid-flush SHALL discard all held words; the array data contents are don't-care, because the tags gate validity.
REQ-035 After reset deasserts, in_ready SHALL be 1 in the first cycle.

Verification
REQ-036 DEPTH=8, out_ready=1, push 6F,7E,0A,3B,2C,99,05,33 back-to-back -> out_valid rises after the 8th accept with out_data=6F, occupancy=8.
REQ-037 Continue pushing 8 more words with out_ready=1 -> outputs 7E,0A,3B,2C,99,05,33 in order; occupancy stays 8.
REQ-038 Hold out_ready=0 with the array full -> in_ready=0, sr_enable=0, out_data stable, occupancy=8.
REQ-039 Push 3 words (A1,A2,A3), then pulse flush with out_ready=1 -> A1,A2,A3 emerge in order; flush_done pulses once; occupancy=0; in_ready=0 throughout FLUSH.
REQ-040 Pulse flush with the array empty -> flush_done pulses on the next edge, with no sr_enable and out_valid=0.
REQ-041 Assert reset=0 mid-flush with 4 words held -> out_valid=0 and occupancy=0 immediately; RUN with in_ready=1 after release.
